serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Sequencing controller that performs a WIDTH-bit addition by reusing one narrow SLICE-bit adder slice over WIDTH/SLICE cycles, instead of instantiating a full-width ripple-carry chain. It accepts one operand pair on a valid/ready input handshake and shifts the operands through the slice least-significant slice first, carrying between cycles in a register. It returns the sum and carry-out on a valid/ready output handshake. It sits beside the combinational RCA64 adder as its area-minimal alternative, and presents the same a/b/cin to s/cout arithmetic.

## Interface
- WIDTH, 64: operand and result width; must be a multiple of SLICE.
- SLICE, 1: bits processed per cycle; legal values are 1, 2, 4 and 8.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- sub  in  1  subtract request; present only with SERIAL_ADD_SUB_EN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- s  out  WIDTH  sum.
- cout  out  1  carry-out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. N = WIDTH/SLICE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a and b into shift registers, set carry register to cin, clear the slice counter, go to RUN.
- RUN:
  - Each cycle, the slice adds the low SLICE bits of A, the low SLICE bits of B, and the carry register.
  - The slice sum shifts into the top of the result register; A and B shift right by SLICE; the carry register takes the slice carry-out.
  - The counter increments. On the cycle with counter==N-1, go to DONE.
- DONE:
  - out_valid=1; s and cout hold stable.
  - On out_ready, go to IDLE.
  - The output handshake completes even if in_valid is also high; no input is accepted in that cycle.
- in_ready is low in RUN and DONE. in_valid is ignored there, and in_ready does not depend on out_ready.
- Arithmetic: {cout,s} = a + b + cin modulo 2^(WIDTH+1).
- Internal sums are SLICE+1 bits wide; no truncation occurs before the final result.

## Timing
- Reset values: state=IDLE, in_ready=0 during the reset cycle and 1 from the first cycle after it, out_valid=0, busy=0, s=0, cout=0, carry=0, counter=0.
- Reset mid-RUN or mid-DONE: the operation is discarded with no out_valid pulse, and s and cout read 0.
- Latency: out_valid rises exactly N cycles after the accepting edge (64 cycles at the defaults).
- Throughput: one operation per N+2 cycles with out_ready held high. The minimum gap is accept edge, N RUN edges, then the DONE handshake edge; in_ready is high again the cycle after that.
- out_valid, s and cout are registered outputs. in_ready and busy are decoded from the state register only.
- s holds its last value through IDLE until the next result is written.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - The sub port exists and is latched at acceptance.
  - When sub=1, B is loaded inverted and the carry register is set to 1, ignoring cin. This gives s = a - b, with cout=1 meaning no borrow.
- SERIAL_ADD_SUB_EN undefined:
  - There is no sub port; add only.
  - Behaviour is identical to the defined case with sub=0.

## Structure
- Package serial_add_pkg:
  - State enum (IDLE, RUN, DONE).
  - Localparam helper computing the counter width as clog2(WIDTH/SLICE), minimum 1.
- Sub-module serial_add_slice:
  - Combinational SLICE-bit ripple of full adders, each built from two half adders plus an OR.
  - Ports: SLICE-bit x, SLICE-bit y, ci, SLICE-bit sum, co.
- The controller holds the FSM, counter, shift registers and carry register only.

## Test plan
- Defaults: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> s=0, cout=1; out_valid rises exactly 64 cycles after the accept edge.
- a=0x0123_4567_89AB_CDEF, b=0xFEDC_BA98_7654_3210, cin=0 -> s=0xFFFF_FFFF_FFFF_FFFF, cout=0. Repeated with cin=1 -> s=0, cout=1.
- Backpressure: out_ready held low for 10 cycles in DONE, with in_valid pulsed meanwhile:
  - s, cout and out_valid stay stable and in_ready stays 0.
  - The pulses are not accepted.
  - When out_ready rises, in_ready returns the next cycle.
- rst asserted on the 20th RUN cycle:
  - Next cycle: in_ready=1, out_valid=0, busy=0, s=0.
  - A following a=5, b=7, cin=0 yields s=12, cout=0.
- SERIAL_ADD_SUB_EN with sub=1:
  - a=5, b=7 -> s=0xFFFF_FFFF_FFFF_FFFE, cout=0.
  - a=7, b=5 -> s=2, cout=1.
- SLICE=4: a=b=0x8000_0000_0000_0000, cin=0 -> s=0, cout=1, with out_valid 16 cycles after accept.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and elaboration helpers for the slice-serial adder controller.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width for WIDTH/SLICE slice steps; never narrower than one bit.
   function automatic int cnt_width(input int width, input int slice);
      int n;
      n = width / slice;
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_add_slice.sv
// Combinational SLICE-bit ripple adder; each full adder is two half adders plus an OR.
module serial_add_slice #(
   parameter int SLICE = 1
) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             ci,
   output logic [SLICE-1:0] sum,
   output logic             co
);

   logic carry;
   logic h1_s;
   logic h1_c;
   logic h2_c;

   // NOTE: blocking assignments here are intentional: the carry variable must
   // update within the loop so each bit sees the ripple from the bit below.
   always_comb begin
      carry = ci;
      h1_s  = 1'b0;
      h1_c  = 1'b0;
      h2_c  = 1'b0;
      sum   = '0;
      for (int i = 0; i < SLICE; i++) begin
         h1_s   = x[i] ^ y[i];
         h1_c   = x[i] & y[i];
         sum[i] = h1_s ^ carry;
         h2_c   = h1_s & carry;
         carry  = h1_c | h2_c;
      end
      co = carry;
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// WIDTH-bit adder that reuses one SLICE-bit slice over WIDTH/SLICE cycles.
// Define SERIAL_ADD_SUB_EN to add the sub port (s = a - b, cout = no borrow).
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int SLICE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             busy
);

   localparam int                 N     = WIDTH / SLICE;
   localparam int                 CNT_W = cnt_width(WIDTH, SLICE);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(N - 1);

   state_t                 state;
   state_t                 state_next;
   logic [WIDTH-1:0]       a_sh;
   logic [WIDTH-1:0]       b_sh;
   logic                   carry;
   logic [CNT_W-1:0]       cnt;
   logic [SLICE-1:0]       slice_sum;
   logic                   slice_co;
   logic [WIDTH+SLICE-1:0] res_cat;
   logic                   sub_eff;
   logic                   accept;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_eff = sub;
`else
   assign sub_eff = 1'b0;
`endif

   assign accept  = in_valid && in_ready;
   assign res_cat = {slice_sum, s};

   serial_add_slice #(.SLICE(SLICE)) u_slice (
      .x   (a_sh[SLICE-1:0]),
      .y   (b_sh[SLICE-1:0]),
      .ci  (carry),
      .sum (slice_sum),
      .co  (slice_co)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: state_next gets a default first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)     state_next = RUN;
         RUN:     if (cnt == LAST)  state_next = DONE;
         DONE:    if (out_ready)    state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state == RUN) || (state == DONE);
   end

   // The result shifts in at the top, so after N steps slice 0 sits at bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh      <= '0;
         b_sh      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         s         <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= sub_eff ? ~b : b;
         carry <= sub_eff ? 1'b1 : cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh  <= a_sh >> SLICE;
         b_sh  <= b_sh >> SLICE;
         s     <= res_cat[WIDTH+SLICE-1:SLICE];
         carry <= slice_co;
         cnt   <= cnt + CNT_W'(1);
         if (cnt == LAST) begin
            cout      <= slice_co;
            out_valid <= 1'b1;
         end
      end else if (state == DONE && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
